alsu_pipe: RTL and testbench
============================

Name: alsu_pipe

Overview:
- Parametrised, pipelined successor to the 3-bit ALSU.
- Configurable operand width, valid/ready handshakes on input and output, and a carry-aware add.
- LED error signalling happens per accepted transaction instead of per clock.
- Sits between the stimulus/driver interface and the result consumer; latency is 2 accepted stages.

Parameters:
- WIDTH, 3, operand width of A and B.
- OUT_W, 2*WIDTH, result width; must be at least WIDTH+1 (elaboration-time check).
- LED_W, 16, width of leds.
- INPUT_PRIORITY, "A", operand chosen when both bypass flags or both reduction flags are set ("A" or "B").
- FULL_ADDER, "ON", "ON" adds cin; "OFF" ignores cin.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- in_valid  in  1  input transaction valid
- in_ready  out  1  block can accept an input this cycle
- A  in  WIDTH  operand A
- B  in  WIDTH  operand B
- cin  in  1  carry in
- serial_in  in  1  shift fill bit
- red_op_A  in  1  reduction on A
- red_op_B  in  1  reduction on B
- opcode  in  3  0 OR, 1 XOR, 2 ADD, 3 MUL, 4 SHIFT, 5 ROTATE, 6/7 invalid
- bypass_A  in  1  pass A through
- bypass_B  in  1  pass B through
- direction  in  1  1 = left, 0 = right
- out_valid  out  1  result valid
- out_ready  in  1  consumer accepts result
- out  out  OUT_W  result
- leds  out  LED_W  error indicator

Behaviour:
- Clock and reset: single clock clk; rst_n is asynchronous, active-low.
- Reset values: out=0, leds=0, out_valid=0, stage-1 valid=0, hence in_ready=1.
  - Asserting rst_n mid-operation discards both stages.
  - No result is emitted for in-flight transactions.
- Pipeline:
  - Stage 1 registers all inputs when in_valid && in_ready.
  - Stage 2 computes from the stage-1 registers and the current out register, then registers out, leds and out_valid.
- Handshake:
  - s2_free = !out_valid || out_ready.
  - in_ready = !s1_valid || s2_free, which is combinational.
  - Stage 1 advances into stage 2 when s1_valid && s2_free.
  - out, leds and out_valid are held stable while out_valid && !out_ready.
- Latency: with out_ready tied high, a result appears 2 cycles after acceptance; throughput is 1 per cycle.
- Invalid condition: opcode in {6,7}, or (red_op_A || red_op_B) with opcode not in {0,1}.
  - Result: out=0 and leds <= ~leds.
  - Any valid result sets leds <= 0.
- Priority order: invalid, then bypass, then opcode.
- Bypass:
  - bypass_A only gives zero-extended A; bypass_B only gives zero-extended B.
  - Both set: INPUT_PRIORITY selects the operand.
- OR/XOR:
  - No reduction flag: bitwise A op B, zero-extended.
  - Reduction flag set: 1-bit reduction of the flagged operand, zero-extended.
  - Both flags set: INPUT_PRIORITY selects the operand.
- ADD: A+B+cin (cin only when FULL_ADDER="ON"); the carry lands in bit WIDTH; upper bits are 0.
- MUL: unsigned A*B, full OUT_W bits.
- SHIFT operates on the current out register (the last produced result, consumed or not):
  - left: {out[OUT_W-2:0], serial_in}
  - right: {serial_in, out[OUT_W-1:1]}
- ROTATE by 1 on the current out register, in the direction given by direction.
- Back-to-back: consecutive SHIFT/ROTATE transactions chain on each successive result.

Optional Feature:
- ALSU_ERR_CNT_EN defined:
  - Adds output err_cnt [7:0], reset 0.
  - Increments once per invalid transaction entering stage 2 and saturates at 8'hFF.
  - Never decrements; only rst_n clears it.
- Macro undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- alsu_pkg holds:
  - opcode_e enum (OR, XOR, ADD, MUL, SHIFT, ROTATE, INVALID_6, INVALID_7)
  - the is_invalid() function
  - PRIO_A/PRIO_B string constants
- Sub-module alsu_compute: purely combinational stage-2 datapath.
  - Inputs: stage-1 fields plus current out.
  - Outputs: next_out and invalid.
- alsu_pipe owns the registers and the handshake.

Test Plan:
- WIDTH=4, out_ready=1; ADD A=4'hF, B=4'h1, cin=1 -> 2 cycles later out=8'h11, out_valid=1, leds=0.
- MUL A=4'hF, B=4'hF -> out=8'hE1; then SHIFT left serial_in=1 -> out=8'hC3; then ROTATE right -> out=8'hE1.
- opcode=6 twice back-to-back -> out=0 both times, leds=16'hFFFF then 16'h0000; with ALSU_ERR_CNT_EN, err_cnt=2. Then OR A=4'h3, red_op_A=1 -> out=8'h01, leds=0.
- bypass_A=bypass_B=1, A=4'h5, B=4'hA -> out=8'h05 with INPUT_PRIORITY="A", 8'h0A with "B"; opcode=2 with red_op_B=1 -> invalid, out=0.
- Backpressure: out_ready=0 for 5 cycles with 3 inputs offered -> only 2 accepted, in_ready=0, out stable; release -> results emerge in order, none lost or duplicated.
- rst_n pulsed low mid-stream with both stages full -> out=0, out_valid=0, leds=0 immediately (asynchronous); no stale result after release.

Source files
------------

// File: rtl/alsu_pipe_pkg.sv
// Shared types and helpers for the pipelined ALSU: opcode encoding,
// operand-priority names and the invalid-transaction rule.
package alsu_pkg;

    typedef enum logic [2:0] {
        OP_OR        = 3'd0,
        OP_XOR       = 3'd1,
        OP_ADD       = 3'd2,
        OP_MUL       = 3'd3,
        OP_SHIFT     = 3'd4,
        OP_ROTATE    = 3'd5,
        OP_INVALID_6 = 3'd6,
        OP_INVALID_7 = 3'd7
    } opcode_e;

    localparam string PRIO_A = "A";
    localparam string PRIO_B = "B";

    // Reduction flags are only meaningful for OR/XOR.
    function automatic logic is_invalid(input opcode_e op, input logic red_a, input logic red_b);
        logic bad_op;
        logic bad_red;
        bad_op  = (op == OP_INVALID_6) || (op == OP_INVALID_7);
        bad_red = (red_a || red_b) && !((op == OP_OR) || (op == OP_XOR));
        return bad_op || bad_red;
    endfunction

endpackage

// File: rtl/alsu_pipe_if.sv
// Handshake and data bundle between the ALSU driver and the alsu_pipe block.
interface alsu_pipe_if #(
    parameter int WIDTH = 3,
    parameter int OUT_W = 2 * WIDTH,
    parameter int LED_W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             cin;
    logic             serial_in;
    logic             red_op_A;
    logic             red_op_B;
    logic [2:0]       opcode;
    logic             bypass_A;
    logic             bypass_B;
    logic             direction;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out;
    logic [LED_W-1:0] leds;

    modport master (
        output in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode,
               bypass_A, bypass_B, direction, out_ready,
        input  in_ready, out_valid, out, leds
    );

    modport slave (
        input  in_valid, A, B, cin, serial_in, red_op_A, red_op_B, opcode,
               bypass_A, bypass_B, direction, out_ready,
        output in_ready, out_valid, out, leds
    );
endinterface

// File: rtl/alsu_pipe_compute.sv
// Combinational stage-2 datapath of alsu_pipe: produces the next result from
// the registered stage-1 fields and the current output register.
module alsu_compute
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter int    OUT_W          = 2 * WIDTH,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             serial_in,
    input  logic             red_a,
    input  logic             red_b,
    input  opcode_e          opcode,
    input  logic             bypass_a,
    input  logic             bypass_b,
    input  logic             direction,
    input  logic [OUT_W-1:0] cur_out,
    output logic [OUT_W-1:0] next_out,
    output logic             invalid
);
    localparam logic PRIO_IS_A = (INPUT_PRIORITY == PRIO_A);
    localparam logic ADD_CIN   = (FULL_ADDER == "ON");

    logic pick_a;
    logic red_pick_a;
    logic red_bit;

    always_comb begin
        invalid    = is_invalid(opcode, red_a, red_b);
        pick_a     = bypass_a && (!bypass_b || PRIO_IS_A);
        red_pick_a = red_a && (!red_b || PRIO_IS_A);
        red_bit    = 1'b0;
        next_out   = '0;

        if (invalid) begin
            next_out = '0;
        end else if (bypass_a || bypass_b) begin
            next_out = pick_a ? OUT_W'(a) : OUT_W'(b);
        end else begin
            case (opcode)
                OP_OR: begin
                    red_bit  = red_pick_a ? (|a) : (|b);
                    next_out = (red_a || red_b) ? OUT_W'(red_bit) : OUT_W'(a | b);
                end
                OP_XOR: begin
                    red_bit  = red_pick_a ? (^a) : (^b);
                    next_out = (red_a || red_b) ? OUT_W'(red_bit) : OUT_W'(a ^ b);
                end
                // OUT_W > WIDTH, so the carry naturally lands in bit WIDTH.
                OP_ADD:  next_out = OUT_W'(a) + OUT_W'(b) + OUT_W'(cin & ADD_CIN);
                OP_MUL:  next_out = OUT_W'(a) * OUT_W'(b);
                OP_SHIFT: next_out = direction ? {cur_out[OUT_W-2:0], serial_in}
                                               : {serial_in, cur_out[OUT_W-1:1]};
                OP_ROTATE: next_out = direction ? {cur_out[OUT_W-2:0], cur_out[OUT_W-1]}
                                                : {cur_out[0], cur_out[OUT_W-1:1]};
                default: next_out = '0;
            endcase
        end
    end

endmodule

// File: rtl/alsu_pipe.sv
// Two-stage valid/ready ALSU. Optional saturating invalid-transaction counter
// on port err_cnt when ALSU_ERR_CNT_EN is defined.
module alsu_pipe
    import alsu_pkg::*;
#(
    parameter int    WIDTH          = 3,
    parameter int    OUT_W          = 2 * WIDTH,
    parameter int    LED_W          = 16,
    parameter string INPUT_PRIORITY = "A",
    parameter string FULL_ADDER     = "ON"
) (
    input  logic       clk,
    input  logic       rst_n,
    alsu_pipe_if.slave bus
`ifdef ALSU_ERR_CNT_EN
    ,
    output logic [7:0] err_cnt
`endif
);
    if (OUT_W < WIDTH + 1) begin : g_bad_out_w
        $error("alsu_pipe: OUT_W must be at least WIDTH+1");
    end

    typedef struct packed {
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic             cin;
        logic             serial_in;
        logic             red_a;
        logic             red_b;
        opcode_e          opcode;
        logic             bypass_a;
        logic             bypass_b;
        logic             direction;
    } s1_t;

    s1_t              s1_d, s1_q, s1_in;
    logic             s1_valid_d, s1_valid_q;
    logic [OUT_W-1:0] out_d, out_q;
    logic [LED_W-1:0] leds_d, leds_q;
    logic             out_valid_d, out_valid_q;
    logic [OUT_W-1:0] next_out;
    logic             invalid;
    logic             s2_free;
    logic             accept;
    logic             advance;

    assign s2_free      = !out_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || s2_free;
    assign accept       = bus.in_valid && bus.in_ready;
    assign advance      = s1_valid_q && s2_free;

    assign bus.out       = out_q;
    assign bus.leds      = leds_q;
    assign bus.out_valid = out_valid_q;

    always_comb begin
        s1_in.a         = bus.A;
        s1_in.b         = bus.B;
        s1_in.cin       = bus.cin;
        s1_in.serial_in = bus.serial_in;
        s1_in.red_a     = bus.red_op_A;
        s1_in.red_b     = bus.red_op_B;
        s1_in.opcode    = opcode_e'(bus.opcode);
        s1_in.bypass_a  = bus.bypass_A;
        s1_in.bypass_b  = bus.bypass_B;
        s1_in.direction = bus.direction;
    end

    alsu_compute #(
        .WIDTH          (WIDTH),
        .OUT_W          (OUT_W),
        .INPUT_PRIORITY (INPUT_PRIORITY),
        .FULL_ADDER     (FULL_ADDER)
    ) u_compute (
        .a         (s1_q.a),
        .b         (s1_q.b),
        .cin       (s1_q.cin),
        .serial_in (s1_q.serial_in),
        .red_a     (s1_q.red_a),
        .red_b     (s1_q.red_b),
        .opcode    (s1_q.opcode),
        .bypass_a  (s1_q.bypass_a),
        .bypass_b  (s1_q.bypass_b),
        .direction (s1_q.direction),
        .cur_out   (out_q),
        .next_out  (next_out),
        .invalid   (invalid)
    );

    always_comb begin
        s1_d        = s1_q;
        s1_valid_d  = s1_valid_q;
        out_d       = out_q;
        leds_d      = leds_q;
        out_valid_d = out_valid_q;

        if (advance) s1_valid_d = 1'b0;
        if (accept) begin
            s1_valid_d = 1'b1;
            s1_d       = s1_in;
        end

        // Stage 2 only moves when the consumer side is free; otherwise hold.
        if (s2_free) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_d  = next_out;
                leds_d = invalid ? ~leds_q : '0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q        <= '0;
            s1_valid_q  <= 1'b0;
            out_q       <= '0;
            leds_q      <= '0;
            out_valid_q <= 1'b0;
        end else begin
            s1_q        <= s1_d;
            s1_valid_q  <= s1_valid_d;
            out_q       <= out_d;
            leds_q      <= leds_d;
            out_valid_q <= out_valid_d;
        end
    end

`ifdef ALSU_ERR_CNT_EN
    logic [7:0] err_cnt_d, err_cnt_q;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (advance && invalid && (err_cnt_q != 8'hFF)) err_cnt_d = err_cnt_q + 8'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err_cnt_q <= '0;
        else        err_cnt_q <= err_cnt_d;
    end

    assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_alsu_pipe.sv
// Directed self-checking bench for alsu_pipe (WIDTH=4); a second instance with
// INPUT_PRIORITY="B" and FULL_ADDER="OFF" sees the same stimulus.
module tb_alsu_pipe;
    localparam int WIDTH = 4;
    localparam int OUT_W = 8;
    localparam int LED_W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    alsu_pipe_if #(.WIDTH(WIDTH), .OUT_W(OUT_W), .LED_W(LED_W)) ifa ();
    alsu_pipe_if #(.WIDTH(WIDTH), .OUT_W(OUT_W), .LED_W(LED_W)) ifb ();

    assign ifb.in_valid  = ifa.in_valid;
    assign ifb.A         = ifa.A;
    assign ifb.B         = ifa.B;
    assign ifb.cin       = ifa.cin;
    assign ifb.serial_in = ifa.serial_in;
    assign ifb.red_op_A  = ifa.red_op_A;
    assign ifb.red_op_B  = ifa.red_op_B;
    assign ifb.opcode    = ifa.opcode;
    assign ifb.bypass_A  = ifa.bypass_A;
    assign ifb.bypass_B  = ifa.bypass_B;
    assign ifb.direction = ifa.direction;
    assign ifb.out_ready = ifa.out_ready;

`ifdef ALSU_ERR_CNT_EN
    logic [7:0] err_cnt_a, err_cnt_b;
`endif

    alsu_pipe #(
        .WIDTH(WIDTH), .OUT_W(OUT_W), .LED_W(LED_W),
        .INPUT_PRIORITY("A"), .FULL_ADDER("ON")
    ) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifa.slave)
`ifdef ALSU_ERR_CNT_EN
        , .err_cnt (err_cnt_a)
`endif
    );

    alsu_pipe #(
        .WIDTH(WIDTH), .OUT_W(OUT_W), .LED_W(LED_W),
        .INPUT_PRIORITY("B"), .FULL_ADDER("OFF")
    ) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (ifb.slave)
`ifdef ALSU_ERR_CNT_EN
        , .err_cnt (err_cnt_b)
`endif
    );

    int n_asserts = 0;
    int n_fail    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_asserts++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // op, A, B, cin, serial_in, direction, red_A, red_B, bypass_A, bypass_B
    task automatic set_in(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                          input logic c, input logic ser, input logic dir,
                          input logic ra, input logic rb, input logic ba, input logic bb);
        ifa.opcode    = op;
        ifa.A         = a;
        ifa.B         = b;
        ifa.cin       = c;
        ifa.serial_in = ser;
        ifa.direction = dir;
        ifa.red_op_A  = ra;
        ifa.red_op_B  = rb;
        ifa.bypass_A  = ba;
        ifa.bypass_B  = bb;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b,
                         input logic c, input logic ser, input logic dir,
                         input logic ra, input logic rb, input logic ba, input logic bb);
        set_in(op, a, b, c, ser, dir, ra, rb, ba, bb);
        ifa.in_valid = 1'b1;
        tick();
        ifa.in_valid = 1'b0;
    endtask

    logic [7:0] bp_exp [3];
    logic [7:0] got_q [$];
    int         idx;
    logic       acc;
    int         vcount;

    initial begin
        rst_n         = 1'b0;
        ifa.in_valid  = 1'b0;
        ifa.out_ready = 1'b1;
        set_in(3'd0, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk);
        tick();
        check("reset_out", ifa.out, 8'h00);
        check("reset_out_valid", ifa.out_valid, 1'b0);
        check("reset_leds", ifa.leds, 16'h0000);
        check("reset_in_ready", ifa.in_ready, 1'b1);
        rst_n = 1'b1;

        // ADD with carry: 15+1+1 = 17; instance B ignores cin
        issue(3'd2, 4'hF, 4'h1, 1, 0, 0, 0, 0, 0, 0);
        tick();
        check("add_cin_out", ifa.out, 8'h11);
        check("add_cin_valid", ifa.out_valid, 1'b1);
        check("add_cin_leds", ifa.leds, 16'h0000);
        check("add_nocin_out_b", ifb.out, 8'h10);

        issue(3'd3, 4'hF, 4'hF, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("mul_out", ifa.out, 8'hE1);
        issue(3'd4, 4'h0, 4'h0, 0, 1, 1, 0, 0, 0, 0);
        tick();
        check("shift_left_out", ifa.out, 8'hC3);
        issue(3'd5, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("rotate_right_out", ifa.out, 8'hE1);

        // two invalid opcodes back-to-back toggle leds twice
        issue(3'd6, 4'h1, 4'h2, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd6, 4'h1, 4'h2, 0, 0, 0, 0, 0, 0, 0);
        check("inv1_out", ifa.out, 8'h00);
        check("inv1_valid", ifa.out_valid, 1'b1);
        check("inv1_leds", ifa.leds, 16'hFFFF);
        tick();
        check("inv2_out", ifa.out, 8'h00);
        check("inv2_leds", ifa.leds, 16'h0000);
`ifdef ALSU_ERR_CNT_EN
        check("err_cnt_two", err_cnt_a, 8'd2);
`endif

        issue(3'd0, 4'h3, 4'h0, 0, 0, 0, 1, 0, 0, 0);
        tick();
        check("or_red_a_out", ifa.out, 8'h01);
        check("or_red_a_leds", ifa.leds, 16'h0000);

        issue(3'd0, 4'h0, 4'hF, 0, 0, 0, 1, 1, 0, 0);
        tick();
        check("or_red_both_prio_a", ifa.out, 8'h00);
        check("or_red_both_prio_b", ifb.out, 8'h01);

        issue(3'd1, 4'h5, 4'h3, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("xor_bitwise", ifa.out, 8'h06);
        issue(3'd1, 4'h0, 4'h7, 0, 0, 0, 0, 1, 0, 0);
        tick();
        check("xor_red_b", ifa.out, 8'h01);

        issue(3'd2, 4'h5, 4'hA, 0, 0, 0, 0, 0, 1, 1);
        tick();
        check("bypass_both_prio_a", ifa.out, 8'h05);
        check("bypass_both_prio_b", ifb.out, 8'h0A);
        issue(3'd3, 4'h5, 4'hA, 0, 0, 0, 0, 0, 0, 1);
        tick();
        check("bypass_b_only", ifa.out, 8'h0A);

        // reduction flag with ADD is invalid and beats bypass
        issue(3'd2, 4'h1, 4'h1, 0, 0, 0, 0, 1, 1, 0);
        tick();
        check("add_red_invalid_out", ifa.out, 8'h00);
        check("add_red_invalid_leds", ifa.leds, 16'hFFFF);
        issue(3'd2, 4'h3, 4'h4, 0, 0, 0, 0, 0, 0, 0);
        tick();
        check("add_plain_out", ifa.out, 8'h07);
        check("add_plain_leds", ifa.leds, 16'h0000);
        issue(3'd4, 4'h0, 4'h0, 0, 1, 0, 0, 0, 0, 0);
        tick();
        check("shift_right_out", ifa.out, 8'h83);
        issue(3'd5, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        check("rotate_left_out", ifa.out, 8'h07);
        tick();
        check("drained_out_valid", ifa.out_valid, 1'b0);

        // backpressure: 5 stalled cycles, 3 offered transactions
        bp_exp[0] = 8'h02;
        bp_exp[1] = 8'h04;
        bp_exp[2] = 8'h06;
        idx = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            ifa.out_ready = (cyc >= 5);
            ifa.in_valid  = (idx < 3);
            if (idx < 3) set_in(3'd2, 4'(idx + 1), 4'(idx + 1), 0, 0, 0, 0, 0, 0, 0);
            @(negedge clk);
            acc = ifa.in_valid && ifa.in_ready;
            if (ifa.out_valid && ifa.out_ready) got_q.push_back(ifa.out);
            if (cyc == 4) begin
                check("bp_accepted", 32'(idx), 32'd2);
                check("bp_in_ready", ifa.in_ready, 1'b0);
                check("bp_out_held", ifa.out, 8'h02);
                check("bp_out_valid_held", ifa.out_valid, 1'b1);
            end
            tick();
            if (acc) idx++;
        end
        ifa.in_valid = 1'b0;
        check("bp_result_count", 32'(got_q.size()), 32'd3);
        for (int i = 0; i < 3; i++) begin
            if (i < got_q.size()) check("bp_result_order", got_q[i], bp_exp[i]);
        end

        // fill both stages, then reset asynchronously mid-cycle
        ifa.out_ready = 1'b0;
        issue(3'd2, 4'h5, 4'h5, 0, 0, 0, 0, 0, 0, 0);
        issue(3'd7, 4'h0, 4'h0, 0, 0, 0, 0, 0, 0, 0);
        check("pre_rst_out", ifa.out, 8'h0A);
        check("pre_rst_in_ready", ifa.in_ready, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_out", ifa.out, 8'h00);
        check("async_rst_out_valid", ifa.out_valid, 1'b0);
        check("async_rst_leds", ifa.leds, 16'h0000);
        check("async_rst_in_ready", ifa.in_ready, 1'b1);
        tick();
        rst_n = 1'b1;
        ifa.out_ready = 1'b1;
        vcount = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (ifa.out_valid) vcount++;
        end
        check("no_stale_after_rst", 32'(vcount), 32'd0);
        tick();
        issue(3'd5, 4'h0, 4'h0, 0, 0, 1, 0, 0, 0, 0);
        tick();
        check("rotate_after_rst", ifa.out, 8'h00);
        check("leds_after_rst", ifa.leds, 16'h0000);
        check("valid_after_rst", ifa.out_valid, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
        $finish;
    end

endmodule
